// File: rtl/fp32_div_pkg.sv
// fp32_div_pkg
// Shared definitions for the sequential binary32 divider: field widths,
// the fixed latency and iteration count, the packed field view of a binary32
// word, operand classes and controller states, plus an operand classifier.
// No ports; imported by fp32_div_seq and fp32_mant_div_r4.
package fp32_div_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam int LATENCY = 16;
    localparam int ITERS   = 13;
    localparam int MANT_W  = FRAC_W + 1;
    localparam int QUOT_W  = 2 * ITERS;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_INF,
        CLS_NAN,
        CLS_NORMAL
    } fpClass_e;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } ctrlState_e;

    // Denormals land in CLS_ZERO on purpose: the divider has no
    // subnormal datapath, so they behave exactly like a signed zero.
    function automatic fpClass_e classify(input fp32_t x);
        fpClass_e cls;
        if (x.exp == '0) begin
            cls = CLS_ZERO;
        end else if (x.exp == EXP_W'(EXP_MAX)) begin
            cls = (x.frac == '0) ? CLS_INF : CLS_NAN;
        end else begin
            cls = CLS_NORMAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fp32_mant_div_r4.sv
// fp32_mant_div_r4
// Radix-4 restoring divider for two normalised 24-bit significands.
// Produces a 26-bit quotient (two bits per cycle over ITERS cycles) whose
// MSB carries weight 1.0, plus a sticky flag for a nonzero final remainder.
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset
//   load_i      capture operands and start a new division (overrides any in flight)
//   dividend_i  dividend significand 1.f
//   divisor_i   divisor significand 1.f
//   quot_o      quotient bits, MSB first
//   sticky_o    remainder nonzero
//   busy_o      iterations still outstanding
module fp32_mant_div_r4
    import fp32_div_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [MANT_W-1:0] dividend_i,
    input  logic [MANT_W-1:0] divisor_i,
    output logic [QUOT_W-1:0] quot_o,
    output logic              sticky_o,
    output logic              busy_o
);

    localparam int REM_W = MANT_W + 2;

    logic [REM_W-1:0]  rem_q;
    logic [MANT_W-1:0] div_q;
    logic [QUOT_W-1:0] quot_q;
    logic [3:0]        iter_q;

    logic [REM_W-1:0] divExt;
    logic [REM_W-1:0] rem1;
    logic [REM_W-1:0] rem1Shift;
    logic [REM_W-1:0] rem2;
    logic [REM_W-1:0] rem_d;
    logic             bitHi;
    logic             bitLo;

    // Two chained restoring steps per cycle. The remainder stays below twice
    // the divisor before each shift, so REM_W bits never overflow.
    always_comb begin
        divExt    = {2'b00, div_q};
        bitHi     = (rem_q >= divExt);
        rem1      = bitHi ? (rem_q - divExt) : rem_q;
        rem1Shift = rem1 << 1;
        bitLo     = (rem1Shift >= divExt);
        rem2      = bitLo ? (rem1Shift - divExt) : rem1Shift;
        rem_d     = rem2 << 1;
    end

    // Load wins over iterating so a restart always begins from fresh operands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            div_q  <= '0;
            quot_q <= '0;
            iter_q <= '0;
        end else if (load_i) begin
            rem_q  <= {2'b00, dividend_i};
            div_q  <= divisor_i;
            quot_q <= '0;
            iter_q <= 4'(ITERS);
        end else if (iter_q != '0) begin
            rem_q  <= rem_d;
            quot_q <= {quot_q[QUOT_W-3:0], bitHi, bitLo};
            iter_q <= iter_q - 4'd1;
        end
    end

    assign quot_o   = quot_q;
    assign sticky_o = |rem_q;
    assign busy_o   = (iter_q != '0);

endmodule

// File: rtl/fp32_div_seq.sv
// fp32_div_seq
// Sequential IEEE-754 binary32 divider, q = a / b, fixed 16-cycle latency.
// A cycle counter sequences: unpack/classify, 13 radix-4 mantissa
// iterations, normalise/round-to-nearest-even/pack, then a done pulse.
// Ports:
//   c      clock, rising edge
//   rst    synchronous active-high reset; aborts any divide in flight
//   a      dividend, sampled with start
//   b      divisor, sampled with start
//   start  launch (or relaunch) a divide
//   q      quotient, held until the next result is packed
//   done   one-cycle pulse marking q valid
module fp32_div_seq
    import fp32_div_pkg::*;
(
    input  logic        c,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        start,
    output logic [31:0] q,
    output logic        done
);

    localparam logic [4:0] CNT_UNPACK = 5'd1;
    localparam logic [4:0] CNT_PACK   = 5'(LATENCY - 1);
    localparam logic [4:0] CNT_DONE   = 5'(LATENCY);

    ctrlState_e         state_q;
    logic [4:0]         cnt_q;
    fp32_t              opA_q;
    fp32_t              opB_q;
    logic               sign_q;
    logic signed [9:0]  expDiff_q;
    logic               special_q;
    logic [31:0]        specialVal_q;
    logic [31:0]        result_q;
    logic               done_q;

    logic               sign_d;
    logic signed [9:0]  expDiff_d;
    logic               special_d;
    logic [31:0]        specialVal_d;
    logic [31:0]        result_d;

    fpClass_e           clsA;
    fpClass_e           clsB;

    logic               divLoad;
    logic [QUOT_W-1:0]  divQuot;
    logic               divSticky;
    logic               divBusy;

    assign divLoad = (state_q == ST_RUN) && (cnt_q == CNT_UNPACK);

    fp32_mant_div_r4 u_mant_div (
        .clk_i      (c),
        .rst_i      (rst),
        .load_i     (divLoad),
        .dividend_i ({1'b1, opA_q.frac}),
        .divisor_i  ({1'b1, opB_q.frac}),
        .quot_o     (divQuot),
        .sticky_o   (divSticky),
        .busy_o     (divBusy)
    );

    // Unpack stage: result sign, biased exponent difference and the special
    // case decision. Checks run in priority order so NaN beats everything.
    always_comb begin
        clsA         = classify(opA_q);
        clsB         = classify(opB_q);
        sign_d       = opA_q.sign ^ opB_q.sign;
        expDiff_d    = $signed({2'b00, opA_q.exp} - {2'b00, opB_q.exp} + 10'(BIAS));
        special_d    = 1'b1;
        specialVal_d = QNAN;
        if (clsA == CLS_NAN || clsB == CLS_NAN) begin
            specialVal_d = QNAN;
        end else if ((clsA == CLS_ZERO && clsB == CLS_ZERO) ||
                     (clsA == CLS_INF  && clsB == CLS_INF)) begin
            specialVal_d = QNAN;
        end else if (clsB == CLS_ZERO || clsA == CLS_INF) begin
            specialVal_d = {sign_d, 8'hFF, 23'd0};
        end else if (clsB == CLS_INF || clsA == CLS_ZERO) begin
            specialVal_d = {sign_d, 31'd0};
        end else begin
            special_d = 1'b0;
        end
    end

    logic              msbSet;
    logic [22:0]       fracPre;
    logic              guardBit;
    logic              restBits;
    logic              roundUp;
    logic [23:0]       fracSum;
    logic signed [9:0] expNorm;
    logic signed [9:0] expRound;

    // Normalise/round/pack. The quotient lies in [0.5, 2): with the MSB set
    // the two tail bits are guard and round; with it clear only a guard bit
    // remains and the remainder alone forms the round|sticky term. A carry
    // out of the fraction leaves it all-zero and bumps the exponent.
    always_comb begin
        msbSet   = divQuot[QUOT_W-1];
        fracPre  = msbSet ? divQuot[24:2] : divQuot[23:1];
        guardBit = msbSet ? divQuot[1] : divQuot[0];
        restBits = msbSet ? (divQuot[0] | divSticky) : divSticky;
        expNorm  = msbSet ? expDiff_q : (expDiff_q - 10'sd1);
        roundUp  = guardBit & (restBits | fracPre[0]);
        fracSum  = {1'b0, fracPre} + {23'd0, roundUp};
        expRound = fracSum[23] ? (expNorm + 10'sd1) : expNorm;
        if (special_q) begin
            result_d = specialVal_q;
        end else if (expRound >= 10'sd255) begin
            result_d = {sign_q, 8'hFF, 23'd0};
        end else if (expRound <= 10'sd0) begin
            result_d = {sign_q, 31'd0};
        end else begin
            result_d = {sign_q, expRound[7:0], fracSum[22:0]};
        end
    end

    // Controller. A start always wins, so an in-flight divide is simply
    // restarted with the new operands and never reaches its pack step.
    always_ff @(posedge c) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            opA_q        <= '0;
            opB_q        <= '0;
            sign_q       <= 1'b0;
            expDiff_q    <= '0;
            special_q    <= 1'b0;
            specialVal_q <= '0;
            result_q     <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                opA_q   <= a;
                opB_q   <= b;
                cnt_q   <= CNT_UNPACK;
                state_q <= ST_RUN;
            end else if (state_q == ST_RUN) begin
                if (cnt_q == CNT_DONE) begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end else begin
                    cnt_q <= cnt_q + 5'd1;
                end
                if (cnt_q == CNT_UNPACK) begin
                    sign_q       <= sign_d;
                    expDiff_q    <= expDiff_d;
                    special_q    <= special_d;
                    specialVal_q <= specialVal_d;
                end
                if (cnt_q == CNT_PACK && !divBusy) begin
                    result_q <= result_d;
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign q    = result_q;
    assign done = done_q;

endmodule

// File: tb/tb_fp32_div_seq.sv
// tb_fp32_div_seq
// Scoreboard bench for fp32_div_seq: stimulus pushes expected quotients with
// their launch cycle, a monitor pops on every done pulse and checks value,
// latency and pulse width; stray done pulses are reported.
module tb_fp32_div_seq;

    logic        c;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic [31:0] q;
    logic        done;

    typedef struct packed {
        logic [31:0] expected;
        logic [31:0] launch;
        logic [31:0] id;
    } expItem_t;

    expItem_t    expQ[$];
    int          checks   = 0;
    int          errors   = 0;
    int          cycleCnt = 0;
    logic        prevDone = 1'b0;
    logic [31:0] lastExp  = '0;

    fp32_div_seq dut (
        .c     (c),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .start (start),
        .q     (q),
        .done  (done)
    );

    // Free-running clock and a rising-edge counter used for latency checks.
    initial begin
        c = 1'b0;
        forever #5 c = ~c;
    end

    initial forever begin
        @(posedge c);
        cycleCnt++;
    end

    // Independent reference for normal operands: exact integer long division
    // of the significands, then normalise and round half to even.
    function automatic logic [31:0] refDiv(input logic [31:0] x, input logic [31:0] y);
        longint unsigned ma, mb, n, qq, rr, sig;
        int  e;
        bit  g, rs, s;
        ma = longint'({1'b1, x[22:0]});
        mb = longint'({1'b1, y[22:0]});
        n  = ma << 25;
        qq = n / mb;
        rr = n % mb;
        e  = int'(x[30:23]) - int'(y[30:23]) + 127;
        s  = x[31] ^ y[31];
        if (qq >= (64'd1 << 25)) begin
            sig = qq >> 2;
            g   = qq[1];
            rs  = qq[0] | (rr != 0);
        end else begin
            sig = qq >> 1;
            g   = qq[0];
            rs  = (rr != 0);
            e   = e - 1;
        end
        if (g && (rs || sig[0])) sig = sig + 1;
        if (sig >= (64'd1 << 24)) begin
            sig = sig >> 1;
            e   = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0)   return {s, 31'd0};
        return {s, e[7:0], sig[22:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
        end
    endtask

    // Drive one launch on a falling edge; garbage follows on the operand
    // ports so any late sampling shows up as a wrong quotient.
    task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB,
                                 input logic [31:0] expVal, input int id, input bit flush);
        expItem_t it;
        @(negedge c);
        a     = opA;
        b     = opB;
        start = 1'b1;
        if (flush) expQ.delete();
        it.expected = expVal;
        it.launch   = 32'(cycleCnt + 1);
        it.id       = 32'(id);
        expQ.push_back(it);
        lastExp = expVal;
        @(negedge c);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic waitDrain(input int id);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 40) begin
            @(negedge c);
            n++;
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_%0d: done not seen after %0d cycles, required within 40", id, n);
            expQ.delete();
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding launch.
    initial forever begin
        expItem_t it;
        @(negedge c);
        if (done === 1'b1) begin
            checkOutput("done_width", {31'd0, prevDone}, 32'd0);
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL stray_done: got done=1 at cycle %0d, required no pulse", cycleCnt);
            end else begin
                it = expQ.pop_front();
                checkOutput($sformatf("q_%0d", it.id), q, it.expected);
                checkOutput($sformatf("latency_%0d", it.id), 32'(cycleCnt) - it.launch, 32'd15);
            end
        end
        prevDone = done;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [31:0] va [14];
    logic [31:0] vb [14];
    logic [31:0] ve [14];

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        va[0]  = 32'h3F80_0000; vb[0]  = 32'h4000_0000; ve[0]  = 32'h3F00_0000;
        va[1]  = 32'h3F80_0000; vb[1]  = 32'h4040_0000; ve[1]  = 32'h3EAA_AAAB;
        va[2]  = 32'h40C0_0000; vb[2]  = 32'h4040_0000; ve[2]  = 32'h4000_0000;
        va[3]  = 32'hC100_0000; vb[3]  = 32'h3F00_0000; ve[3]  = 32'hC180_0000;
        va[4]  = 32'h3F80_0000; vb[4]  = 32'h3FCC_B55A; ve[4]  = refDiv(32'h3F80_0000, 32'h3FCC_B55A);
        va[5]  = 32'h3F80_0000; vb[5]  = 32'h0000_0000; ve[5]  = 32'h7F80_0000;
        va[6]  = 32'hBF80_0000; vb[6]  = 32'h0000_0000; ve[6]  = 32'hFF80_0000;
        va[7]  = 32'h0000_0000; vb[7]  = 32'h0000_0000; ve[7]  = 32'h7FC0_0000;
        va[8]  = 32'h7F80_0000; vb[8]  = 32'h7F80_0000; ve[8]  = 32'h7FC0_0000;
        va[9]  = 32'h3F80_0000; vb[9]  = 32'h7F80_0000; ve[9]  = 32'h0000_0000;
        va[10] = 32'h7FA0_0000; vb[10] = 32'h3F80_0000; ve[10] = 32'h7FC0_0000;
        va[11] = 32'h7F7F_FFFF; vb[11] = 32'h3F00_0000; ve[11] = 32'h7F80_0000;
        va[12] = 32'h0080_0000; vb[12] = 32'h4000_0000; ve[12] = 32'h0000_0000;
        va[13] = 32'h0000_0001; vb[13] = 32'h3F80_0000; ve[13] = 32'h0000_0000;

        repeat (3) @(negedge c);
        checkOutput("reset_q", q, 32'h0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge c);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(va[i], vb[i], ve[i], i, 1'b0);
            waitDrain(i);
            @(negedge c);
        end

        repeat (6) @(negedge c);
        checkOutput("hold_q", q, lastExp);

        // Restart: second launch lands on the edge where the counter reads 5.
        applyStimulus(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 100, 1'b0);
        repeat (3) @(negedge c);
        applyStimulus(32'h40C0_0000, 32'h4040_0000, 32'h4000_0000, 101, 1'b1);
        waitDrain(101);
        repeat (20) @(negedge c);
        checkOutput("restart_hold_q", q, 32'h4000_0000);

        // Reset mid-operation: no done may follow and q returns to zero.
        applyStimulus(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 200, 1'b0);
        repeat (4) @(negedge c);
        rst = 1'b1;
        expQ.delete();
        @(negedge c);
        rst = 1'b0;
        repeat (25) @(negedge c);
        checkOutput("midrst_q", q, 32'h0);
        checkOutput("midrst_done", {31'd0, done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
